obi_mem_arbiter: RTL and testbench
==================================

Name: obi_mem_arbiter

Overview:
Two-host to one-device OBI arbiter that lets the fetch stage's instruction port (host 0) and the memory stage's data port (host 1) share a single unified memory port. It sits between the core's imem/dmem OBI host drivers and the external memory bus. It performs round-robin arbitration on the address phase. It records the owner of each granted transaction in an in-order owner FIFO and routes each rvalid back to that owner.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, read/write data width; host 0 zero-extends its 32-bit write data
BE_W, 8, byte-enable width (DATA_W/8)
MAX_OUTSTANDING, 2, maximum accepted-but-unresponded transactions (power of 2, ≥1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
h0_req_i / h1_req_i  in  1  host address-phase request
h0_gnt_o / h1_gnt_o  out  1  host grant
h0_addr_i / h1_addr_i  in  ADDR_W  address
h0_we_i / h1_we_i  in  1  write enable
h0_be_i / h1_be_i  in  BE_W  byte enables
h0_wdata_i / h1_wdata_i  in  DATA_W  write data
h0_rvalid_o / h1_rvalid_o  out  1  response valid for that host
h0_rdata_o / h1_rdata_o  out  DATA_W  read data, broadcast copy of dev_rdata_i
dev_req_o  out  1  device request
dev_gnt_i  in  1  device grant
dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o  out  ADDR_W/1/BE_W/DATA_W  muxed address phase
dev_rvalid_i  in  1  device response valid
dev_rdata_i  in  DATA_W  device read data
outstanding_o  out  clog2(MAX_OUTSTANDING)+1  current owner-FIFO occupancy
err_o  out  1  sticky protocol error flag

Behaviour:
- One clock, clk_i. rst_i is synchronous and active-high.
- Reset clears these to 0: owner FIFO (occupancy 0), lock_q, lock_owner_q, prio_q, err_o. prio_q=0 means host 0 wins a tie. All outputs are combinational from state and inputs.
- Selection, combinational:
  - If lock_q=1, sel=lock_owner_q.
  - Otherwise, if the FIFO is full, no selection: dev_req_o=0 and both gnts=0.
  - Otherwise, if only one host requests, select it. If both request, select prio_q.
- dev_req_o = sel host's req. dev_addr/we/be/wdata = sel host's fields. With no requester, drive the host 0 fields.
- hN_gnt_o = dev_gnt_i & dev_req_o & (sel==N). The unselected host's gnt is always 0. Zero-cycle grant path.
- Lock: the OBI address phase must stay stable until granted.
  - dev_req_o & ~dev_gnt_i → next cycle lock_q=1, lock_owner_q=sel.
  - dev_req_o & dev_gnt_i → lock_q=0.
  - A locked host is never preempted.
- Accept (dev_req_o & dev_gnt_i): push sel into the owner FIFO; prio_q ← ~sel.
- Response (dev_rvalid_i):
  - FIFO non-empty: pop the head; h[head]_rvalid_o=1 in the same cycle; the other host's rvalid=0.
  - FIFO empty: drop the response (both rvalid=0) and set err_o=1 until reset.
- Accept and response in the same cycle: push and pop both happen, occupancy unchanged. When full, a simultaneous pop does not enable a same-cycle grant; the full check uses registered occupancy.
- Responses return in order. Latency is 0 arbiter cycles on both phases. Back-to-back grants every cycle are allowed while not full.
- Reset mid-transaction flushes FIFO and lock. A late device response after reset raises err_o. System reset must cover the memory as well.

Decomposition:
- Lucid64.vh: `HOST_IMEM=1'b0`, `HOST_DMEM=1'b1`, and the default MAX_OUTSTANDING define.
- Sub-module obi_owner_fifo: 1-bit-wide synchronous FIFO of depth MAX_OUTSTANDING.
  - Ports: push, pop, din, dout, full, empty, count.
  - Simultaneous push/pop allowed; count wraps via pointer MSB.
- The top module holds the arbitration, lock and routing logic.

Test Plan:
- Single host: h0_req=1 addr=0x1000, dev_gnt=1 → h0_gnt=1 same cycle, outstanding 0→1. dev_rvalid next cycle, rdata=0xDEAD → h0_rvalid=1, h0_rdata=0xDEAD, h1_rvalid=0, outstanding→0.
- Tie round-robin: both req continuously, dev_gnt=1 every cycle, rvalid one cycle later → grant order h0,h1,h0,h1. Responses routed h0,h1,h0,h1.
- Lock: both req, dev_gnt=0 for 3 cycles, then 1 → dev_addr holds h0's 0x1000 all 4 cycles. h1 not granted until the following cycle.
- Full: MAX_OUTSTANDING=2, two grants with no rvalid → third req sees dev_req_o=0, gnts=0. One rvalid → next cycle grant resumes, outstanding stays ≤2.
- Simultaneous push/pop at occupancy 1 → occupancy stays 1. Owner order preserved: h1 then h0 responses route correctly.
- Spurious rvalid with FIFO empty → no host rvalid, err_o=1 and stays 1 until rst_i=1 for one cycle, after which all state is 0.

Source files
------------

// File: rtl/obi_mem_arbiter_pkg.sv
// Shared types for the two-host OBI memory arbiter.
// Host identifiers and the default outstanding-transaction depth.
package obi_mem_arbiter_pkg;

  typedef enum logic {
    HOST_IMEM = 1'b0,
    HOST_DMEM = 1'b1
  } host_e;

  localparam int unsigned DEF_MAX_OUTSTANDING = 2;

  function automatic host_e other_host(input host_e h);
    return host_e'(~h);
  endfunction

endpackage

// File: rtl/obi_owner_fifo.sv
// In-order owner FIFO: one bit per accepted transaction.
// Pointer MSB distinguishes full from empty.
module obi_owner_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     din_i,
  output logic                     dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  assign wr_idx  = (DEPTH == 1) ? '0 : wr_q[IW-1:0];
  assign rd_idx  = (DEPTH == 1) ? '0 : rd_q[IW-1:0];
  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == PW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign dout_o  = mem_q[rd_idx];

  // Next pointers and storage; push and pop may coincide.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (push_i) begin
      mem_d[wr_idx] = din_i;
      wr_d          = wr_q + 1'b1;
    end
    if (pop_i) begin
      rd_d = rd_q + 1'b1;
    end
  end

  // Pointer and storage registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI device port between
// the instruction (host 0) and data (host 1) ports.
module obi_mem_arbiter
  import obi_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned BE_W            = 8,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               h0_req_i,
  output logic                               h0_gnt_o,
  input  logic [ADDR_W-1:0]                  h0_addr_i,
  input  logic                               h0_we_i,
  input  logic [BE_W-1:0]                    h0_be_i,
  input  logic [DATA_W-1:0]                  h0_wdata_i,
  output logic                               h0_rvalid_o,
  output logic [DATA_W-1:0]                  h0_rdata_o,
  input  logic                               h1_req_i,
  output logic                               h1_gnt_o,
  input  logic [ADDR_W-1:0]                  h1_addr_i,
  input  logic                               h1_we_i,
  input  logic [BE_W-1:0]                    h1_be_i,
  input  logic [DATA_W-1:0]                  h1_wdata_i,
  output logic                               h1_rvalid_o,
  output logic [DATA_W-1:0]                  h1_rdata_o,
  output logic                               dev_req_o,
  input  logic                               dev_gnt_i,
  output logic [ADDR_W-1:0]                  dev_addr_o,
  output logic                               dev_we_o,
  output logic [BE_W-1:0]                    dev_be_o,
  output logic [DATA_W-1:0]                  dev_wdata_o,
  input  logic                               dev_rvalid_i,
  input  logic [DATA_W-1:0]                  dev_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  logic  lock_q, lock_d;
  host_e lock_owner_q, lock_owner_d;
  host_e prio_q, prio_d;
  logic  err_q, err_d;
  host_e sel;
  logic  accept;
  logic  pop;
  logic  fifo_full;
  logic  fifo_empty;
  logic  head_bit;
  host_e head;

  obi_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   (sel),
    .dout_o  (head_bit),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  assign head = host_e'(head_bit);

  // Pick the address-phase owner: lock, then full gate, then round-robin.
  always_comb begin
    sel       = HOST_IMEM;
    dev_req_o = 1'b0;
    if (lock_q) begin
      sel       = lock_owner_q;
      dev_req_o = (lock_owner_q == HOST_DMEM) ? h1_req_i : h0_req_i;
    end else if (!fifo_full) begin
      unique case ({h1_req_i, h0_req_i})
        2'b11:   sel = prio_q;
        2'b10:   sel = HOST_DMEM;
        default: sel = HOST_IMEM;
      endcase
      dev_req_o = h0_req_i | h1_req_i;
    end
  end

  assign dev_addr_o  = (sel == HOST_DMEM) ? h1_addr_i  : h0_addr_i;
  assign dev_we_o    = (sel == HOST_DMEM) ? h1_we_i    : h0_we_i;
  assign dev_be_o    = (sel == HOST_DMEM) ? h1_be_i    : h0_be_i;
  assign dev_wdata_o = (sel == HOST_DMEM) ? h1_wdata_i : h0_wdata_i;

  assign accept   = dev_req_o & dev_gnt_i;
  assign h0_gnt_o = accept & (sel == HOST_IMEM);
  assign h1_gnt_o = accept & (sel == HOST_DMEM);

  assign pop         = dev_rvalid_i & ~fifo_empty;
  assign h0_rvalid_o = pop & (head == HOST_IMEM);
  assign h1_rvalid_o = pop & (head == HOST_DMEM);
  assign h0_rdata_o  = dev_rdata_i;
  assign h1_rdata_o  = dev_rdata_i;
  assign err_o       = err_q;

  // Lock a stalled request, rotate priority on accept, flag orphan responses.
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    prio_d       = prio_q;
    err_d        = err_q | (dev_rvalid_i & fifo_empty);
    if (accept) begin
      lock_d = 1'b0;
      prio_d = other_host(sel);
    end else if (dev_req_o) begin
      lock_d       = 1'b1;
      lock_owner_d = sel;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      lock_owner_q <= HOST_IMEM;
      prio_q       <= HOST_IMEM;
      err_q        <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      prio_q       <= prio_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for the two-host OBI arbiter.
// Inputs change 1 time unit after posedge; outputs checked 1 unit later.
module tb_obi_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int MO = 2;
  localparam int CW = $clog2(MO) + 1;

  logic          clk;
  logic          rst;
  logic          h0_req, h0_gnt, h0_we, h0_rvalid;
  logic [AW-1:0] h0_addr;
  logic [BW-1:0] h0_be;
  logic [DW-1:0] h0_wdata, h0_rdata;
  logic          h1_req, h1_gnt, h1_we, h1_rvalid;
  logic [AW-1:0] h1_addr;
  logic [BW-1:0] h1_be;
  logic [DW-1:0] h1_wdata, h1_rdata;
  logic          dev_req, dev_gnt, dev_we, dev_rvalid;
  logic [AW-1:0] dev_addr;
  logic [BW-1:0] dev_be;
  logic [DW-1:0] dev_wdata, dev_rdata;
  logic [CW-1:0] outstanding;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;

  obi_mem_arbiter #(
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .BE_W            (BW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .h0_req_i      (h0_req),
    .h0_gnt_o      (h0_gnt),
    .h0_addr_i     (h0_addr),
    .h0_we_i       (h0_we),
    .h0_be_i       (h0_be),
    .h0_wdata_i    (h0_wdata),
    .h0_rvalid_o   (h0_rvalid),
    .h0_rdata_o    (h0_rdata),
    .h1_req_i      (h1_req),
    .h1_gnt_o      (h1_gnt),
    .h1_addr_i     (h1_addr),
    .h1_we_i       (h1_we),
    .h1_be_i       (h1_be),
    .h1_wdata_i    (h1_wdata),
    .h1_rvalid_o   (h1_rvalid),
    .h1_rdata_o    (h1_rdata),
    .dev_req_o     (dev_req),
    .dev_gnt_i     (dev_gnt),
    .dev_addr_o    (dev_addr),
    .dev_we_o      (dev_we),
    .dev_be_o      (dev_be),
    .dev_wdata_o   (dev_wdata),
    .dev_rvalid_i  (dev_rvalid),
    .dev_rdata_i   (dev_rdata),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    h0_req     = 1'b0;
    h1_req     = 1'b0;
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    h0_addr    = 64'h1000;
    h0_we      = 1'b0;
    h0_be      = 8'h0f;
    h0_wdata   = 64'h0;
    h1_addr    = 64'h2000;
    h1_we      = 1'b1;
    h1_be      = 8'hff;
    h1_wdata   = 64'h5555_aaaa_5555_aaaa;
    dev_rdata  = 64'h0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_dev_req", 64'(dev_req), 64'd0);

    // single host read
    h0_req  = 1'b1;
    dev_gnt = 1'b1;
    settle();
    chk("single_h0_gnt", 64'(h0_gnt), 64'd1);
    chk("single_h1_gnt", 64'(h1_gnt), 64'd0);
    chk("single_addr", dev_addr, 64'h1000);
    chk("single_we", 64'(dev_we), 64'd0);
    chk("single_be", 64'(dev_be), 64'h0f);
    tick();
    chk("single_occ1", 64'(outstanding), 64'd1);
    h0_req     = 1'b0;
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b1;
    dev_rdata  = 64'hDEAD;
    settle();
    chk("single_h0_rvalid", 64'(h0_rvalid), 64'd1);
    chk("single_h1_rvalid", 64'(h1_rvalid), 64'd0);
    chk("single_rdata", h0_rdata, 64'hDEAD);
    tick();
    dev_rvalid = 1'b0;
    chk("single_occ0", 64'(outstanding), 64'd0);
    chk("single_err", 64'(err), 64'd0);

    // tie round-robin with one-cycle response
    do_reset();
    for (int i = 0; i < 5; i++) begin
      h0_req     = (i < 4);
      h1_req     = (i < 4);
      dev_gnt    = (i < 4);
      dev_rvalid = (i > 0);
      dev_rdata  = 64'(i);
      settle();
      chk($sformatf("rr_h0_gnt%0d", i), 64'(h0_gnt),
          64'((i < 4) && (i % 2 == 0)));
      chk($sformatf("rr_h1_gnt%0d", i), 64'(h1_gnt),
          64'((i < 4) && (i % 2 == 1)));
      chk($sformatf("rr_h0_rv%0d", i), 64'(h0_rvalid),
          64'((i > 0) && ((i - 1) % 2 == 0)));
      chk($sformatf("rr_h1_rv%0d", i), 64'(h1_rvalid),
          64'((i > 0) && ((i - 1) % 2 == 1)));
      chk($sformatf("rr_occ%0d", i), 64'(outstanding), 64'(i > 0));
      tick();
    end
    idle();
    chk("rr_occ_end", 64'(outstanding), 64'd0);

    // lock holds h0 even though priority points at h1
    do_reset();
    h0_req  = 1'b1;
    dev_gnt = 1'b1;
    settle();
    chk("lk_pre_gnt", 64'(h0_gnt), 64'd1);
    tick();
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b1;
    dev_rdata  = 64'hAA;
    settle();
    chk("lk_pre_rvalid", 64'(h0_rvalid), 64'd1);
    chk("lk_stall_req", 64'(dev_req), 64'd1);
    tick();
    dev_rvalid = 1'b0;
    h1_req     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("lk_addr%0d", i), dev_addr, 64'h1000);
      chk($sformatf("lk_h0_gnt%0d", i), 64'(h0_gnt), 64'd0);
      chk($sformatf("lk_h1_gnt%0d", i), 64'(h1_gnt), 64'd0);
      tick();
    end
    dev_gnt = 1'b1;
    settle();
    chk("lk_rel_addr", dev_addr, 64'h1000);
    chk("lk_rel_h0_gnt", 64'(h0_gnt), 64'd1);
    chk("lk_rel_h1_gnt", 64'(h1_gnt), 64'd0);
    tick();
    settle();
    chk("lk_next_h1_gnt", 64'(h1_gnt), 64'd1);
    chk("lk_next_addr", dev_addr, 64'h2000);
    chk("lk_next_we", 64'(dev_we), 64'd1);
    chk("lk_next_wdata", dev_wdata, 64'h5555_aaaa_5555_aaaa);
    tick();

    // full: owners h0,h1 outstanding
    settle();
    chk("full_occ", 64'(outstanding), 64'd2);
    chk("full_dev_req", 64'(dev_req), 64'd0);
    chk("full_h0_gnt", 64'(h0_gnt), 64'd0);
    chk("full_h1_gnt", 64'(h1_gnt), 64'd0);
    tick();
    dev_rvalid = 1'b1;
    dev_rdata  = 64'h11;
    settle();
    chk("full_pop_h0_rv", 64'(h0_rvalid), 64'd1);
    chk("full_pop_h1_rv", 64'(h1_rvalid), 64'd0);
    chk("full_pop_no_req", 64'(dev_req), 64'd0);
    tick();
    dev_rvalid = 1'b0;
    settle();
    chk("full_resume_occ", 64'(outstanding), 64'd1);
    chk("full_resume_h0", 64'(h0_gnt), 64'd1);
    tick();
    idle();
    dev_rvalid = 1'b1;
    dev_rdata  = 64'h22;
    settle();
    chk("full_refill_occ", 64'(outstanding), 64'd2);
    chk("full_drain_h1_rv", 64'(h1_rvalid), 64'd1);
    chk("full_drain_h1_rd", h1_rdata, 64'h22);
    tick();
    settle();
    chk("full_drain_h0_rv", 64'(h0_rvalid), 64'd1);
    tick();
    dev_rvalid = 1'b0;
    chk("full_drain_occ", 64'(outstanding), 64'd0);

    // simultaneous push and pop at occupancy 1
    h1_req  = 1'b1;
    dev_gnt = 1'b1;
    settle();
    chk("pp_h1_gnt", 64'(h1_gnt), 64'd1);
    tick();
    h1_req     = 1'b0;
    h0_req     = 1'b1;
    dev_rvalid = 1'b1;
    settle();
    chk("pp_h0_gnt", 64'(h0_gnt), 64'd1);
    chk("pp_h1_rv", 64'(h1_rvalid), 64'd1);
    chk("pp_h0_rv", 64'(h0_rvalid), 64'd0);
    tick();
    idle();
    dev_rvalid = 1'b1;
    settle();
    chk("pp_occ", 64'(outstanding), 64'd1);
    chk("pp_tail_h0_rv", 64'(h0_rvalid), 64'd1);
    chk("pp_tail_h1_rv", 64'(h1_rvalid), 64'd0);
    tick();
    dev_rvalid = 1'b0;
    chk("pp_occ_end", 64'(outstanding), 64'd0);

    // reset mid-transaction, then a late response
    h0_req  = 1'b1;
    dev_gnt = 1'b1;
    tick();
    chk("mid_occ", 64'(outstanding), 64'd1);
    do_reset();
    chk("mid_rst_occ", 64'(outstanding), 64'd0);
    dev_rvalid = 1'b1;
    settle();
    chk("late_h0_rv", 64'(h0_rvalid), 64'd0);
    chk("late_h1_rv", 64'(h1_rvalid), 64'd0);
    tick();
    dev_rvalid = 1'b0;
    chk("late_err", 64'(err), 64'd1);
    tick();
    tick();
    chk("err_sticky", 64'(err), 64'd1);
    do_reset();
    chk("err_clear", 64'(err), 64'd0);
    chk("err_clear_occ", 64'(outstanding), 64'd0);
    h0_req  = 1'b1;
    h1_req  = 1'b1;
    dev_gnt = 1'b1;
    settle();
    chk("post_rst_prio", 64'(h0_gnt), 64'd1);
    tick();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
